// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and run control for a single-cycle core.
// Owns the PC that addresses the instruction ROM, applies the decoder's
// halt/branch controls each cycle, sequences start/halt/done, and counts
// retired instructions with a saturating counter.
module pc_sequencer #(
    parameter int            IW         = 16,
    parameter logic [IW-1:0] START_ADDR = '0,
    parameter int            CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          halt_i,
    input  logic          branch_i,
    input  logic          branch_type_i,
    input  logic          zero_i,
    input  logic [7:0]    target_i,
    output logic [IW-1:0] pc_o,
    output logic          run_o,
    output logic          done,
    output logic [CW-1:0] icount_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [CW-1:0] icount_q, icount_d;

    // Retired-instruction count sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    // PC-relative target: offset is a signed byte, wrap is silent.
    function automatic logic [IW-1:0] rel_target(input logic [IW-1:0] pc,
                                                 input logic [7:0]    off);
        logic signed [IW-1:0] off_sx;
        off_sx = {{(IW-8){off[7]}}, off};
        return pc + $unsigned(off_sx);
    endfunction

    // Next PC for a retiring, non-halting instruction: absolute jump beats
    // a taken relative branch, which beats fall-through.
    function automatic logic [IW-1:0] next_pc(input logic [IW-1:0] pc,
                                              input logic          br,
                                              input logic          br_abs,
                                              input logic          zero,
                                              input logic [7:0]    tgt);
        if (br && br_abs) begin
            return {{(IW-8){1'b0}}, tgt};
        end else if (br && zero) begin
            return rel_target(pc, tgt);
        end else begin
            return pc + {{(IW-1){1'b0}}, 1'b1};
        end
    endfunction

    // State, PC and counter registers; reset returns everything to the
    // pre-start condition regardless of the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= START_ADDR;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
        end
    end

    // Next-state and next-datapath logic; one instruction retires per RUN cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                // Decoder controls are meaningless outside RUN; only start matters.
                if (start) begin
                    state_d  = ST_RUN;
                    pc_d     = START_ADDR;
                    icount_d = '0;
                end
            end
            ST_RUN: begin
                // The halt instruction itself retires and is counted; any
                // branch raised alongside it is dropped.
                icount_d = sat_inc(icount_q);
                if (halt_i) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_d = next_pc(pc_q, branch_i, branch_type_i, zero_i, target_i);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        run_o = (state_q == ST_RUN);
        done  = (state_q == ST_HALTED);
    end

    assign pc_o     = pc_q;
    assign icount_o = icount_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vectors drive three builds (default,
// START_ADDR=0xFFFF, CW=4); expected post-edge outputs go into a queue and a
// monitor on the falling edge pops and compares them.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, halt_i, branch_i, branch_type_i, zero_i;
    logic [7:0]  target_i;

    logic [15:0] pc_a, pc_b, pc_c;
    logic        run_a, run_b, run_c;
    logic        done_a, done_b, done_c;
    logic [15:0] ic_a, ic_b;
    logic [3:0]  ic_c;

    always #5 clk = ~clk;

    pc_sequencer #(.IW(16), .START_ADDR(16'h0000), .CW(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .halt_i(halt_i),
        .branch_i(branch_i), .branch_type_i(branch_type_i), .zero_i(zero_i),
        .target_i(target_i), .pc_o(pc_a), .run_o(run_a), .done(done_a),
        .icount_o(ic_a));

    pc_sequencer #(.IW(16), .START_ADDR(16'hFFFF), .CW(16)) dut_b (
        .clk(clk), .reset(reset), .start(start), .halt_i(halt_i),
        .branch_i(branch_i), .branch_type_i(branch_type_i), .zero_i(zero_i),
        .target_i(target_i), .pc_o(pc_b), .run_o(run_b), .done(done_b),
        .icount_o(ic_b));

    pc_sequencer #(.IW(16), .START_ADDR(16'h0000), .CW(4)) dut_c (
        .clk(clk), .reset(reset), .start(start), .halt_i(halt_i),
        .branch_i(branch_i), .branch_type_i(branch_type_i), .zero_i(zero_i),
        .target_i(target_i), .pc_o(pc_c), .run_o(run_c), .done(done_c),
        .icount_o(ic_c));

    typedef struct {
        int          sel;
        logic [15:0] pc;
        logic        run;
        logic        done;
        logic [15:0] ic;
        string       name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    exp_t        m_e;
    logic [15:0] m_pc, m_ic;
    logic        m_run, m_done;

    // Monitor: compare each queued expectation against the selected build.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.sel)
                0: begin m_pc = pc_a; m_run = run_a; m_done = done_a; m_ic = ic_a; end
                1: begin m_pc = pc_b; m_run = run_b; m_done = done_b; m_ic = ic_b; end
                default: begin m_pc = pc_c; m_run = run_c; m_done = done_c; m_ic = {12'h000, ic_c}; end
            endcase
            checks++;
            if (m_pc !== m_e.pc || m_run !== m_e.run || m_done !== m_e.done || m_ic !== m_e.ic) begin
                errors++;
                $display("FAIL %s: got pc=%h run=%b done=%b icount=%0d, want pc=%h run=%b done=%b icount=%0d",
                         m_e.name, m_pc, m_run, m_done, m_ic, m_e.pc, m_e.run, m_e.done, m_e.ic);
            end
        end
    end

    // ctl = {reset, start, halt, branch, branch_type, zero}; fl = {run, done}
    task automatic step(input int sel, input logic [5:0] ctl, input logic [7:0] t,
                        input logic [15:0] epc, input logic [1:0] fl,
                        input logic [15:0] eic, input string nm);
        exp_t e;
        {reset, start, halt_i, branch_i, branch_type_i, zero_i} = ctl;
        target_i = t;
        @(posedge clk);
        #1;
        e.sel  = sel;
        e.pc   = epc;
        e.run  = fl[1];
        e.done = fl[0];
        e.ic   = eic;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic run(input int sel, input logic [15:0] epc, input logic [15:0] eic,
                       input string nm);
        step(sel, 6'b000000, 8'h00, epc, 2'b10, eic, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {reset, start, halt_i, branch_i, branch_type_i, zero_i} = 6'b100000;
        target_i = 8'h00;

        // Build A: reset, idle with decoder noise
        step(0, 6'b100000, 8'h00, 16'h0000, 2'b00, 16'd0, "reset1");
        step(0, 6'b100000, 8'h00, 16'h0000, 2'b00, 16'd0, "reset2");
        for (int i = 0; i < 10; i++)
            step(0, {2'b00, i[0], i[1], i[2], i[3]}, 8'h80, 16'h0000, 2'b00, 16'd0, "idle_ignore");

        // Sequential run then halt at PC 5
        step(0, 6'b010000, 8'h00, 16'h0000, 2'b10, 16'd0, "start");
        for (int i = 1; i <= 5; i++) run(0, 16'(i), 16'(i), "seq");
        step(0, 6'b001000, 8'h00, 16'h0005, 2'b01, 16'd6, "halt");
        for (int i = 0; i < 10; i++)
            step(0, {2'b00, i[0], ~i[0], 2'b11}, 8'h40, 16'h0005, 2'b01, 16'd6, "halt_hold");

        // Restart from HALTED, then branches
        step(0, 6'b010000, 8'h00, 16'h0000, 2'b10, 16'd0, "restart");
        run(0, 16'h0001, 16'd1, "seq");
        run(0, 16'h0002, 16'd2, "seq");
        run(0, 16'h0003, 16'd3, "seq");
        step(0, 6'b000101, 8'hFE, 16'h0001, 2'b10, 16'd4, "rel_taken");
        run(0, 16'h0002, 16'd5, "seq");
        run(0, 16'h0003, 16'd6, "seq");
        step(0, 6'b000100, 8'hFE, 16'h0004, 2'b10, 16'd7, "rel_not_taken");
        step(0, 6'b000110, 8'h80, 16'h0080, 2'b10, 16'd8, "abs_80");
        step(0, 6'b000110, 8'hFF, 16'h00FF, 2'b10, 16'd9, "abs_ff");
        step(0, 6'b000101, 8'h7F, 16'h017E, 2'b10, 16'd10, "rel_pos");
        step(0, 6'b000111, 8'h02, 16'h0002, 2'b10, 16'd11, "abs_2");
        step(0, 6'b000101, 8'hFC, 16'hFFFE, 2'b10, 16'd12, "rel_neg_wrap");
        run(0, 16'hFFFF, 16'd13, "seq");
        run(0, 16'h0000, 16'd14, "pc_wrap");
        for (int i = 1; i <= 7; i++) run(0, 16'(i), 16'(14 + i), "seq");
        step(0, 6'b001111, 8'h80, 16'h0007, 2'b01, 16'd22, "halt_and_branch");
        step(0, 6'b000000, 8'h00, 16'h0007, 2'b01, 16'd22, "halt_hold2");

        // Start ignored while running; reset beats start mid-run
        step(0, 6'b010000, 8'h00, 16'h0000, 2'b10, 16'd0, "restart2");
        step(0, 6'b010000, 8'h00, 16'h0001, 2'b10, 16'd1, "start_in_run");
        for (int i = 2; i <= 9; i++) run(0, 16'(i), 16'(i), "seq");
        step(0, 6'b110000, 8'h00, 16'h0000, 2'b00, 16'd0, "reset_with_start");
        step(0, 6'b000000, 8'h00, 16'h0000, 2'b00, 16'd0, "idle_after_reset");

        // Build B: START_ADDR = 0xFFFF, sequential wrap
        step(1, 6'b100000, 8'h00, 16'hFFFF, 2'b00, 16'd0, "b_reset");
        step(1, 6'b010000, 8'h00, 16'hFFFF, 2'b10, 16'd0, "b_start");
        run(1, 16'h0000, 16'd1, "b_wrap");
        run(1, 16'h0001, 16'd2, "b_seq");

        // Build C: CW = 4, counter saturation
        step(2, 6'b100000, 8'h00, 16'h0000, 2'b00, 16'd0, "c_reset");
        step(2, 6'b010000, 8'h00, 16'h0000, 2'b10, 16'd0, "c_start");
        for (int i = 1; i <= 20; i++) run(2, 16'(i), (i > 15) ? 16'd15 : 16'(i), "c_sat");
        step(2, 6'b001000, 8'h00, 16'd20, 2'b01, 16'd15, "c_halt_sat");

        // Let the monitor drain the queue
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control stage sitting directly upstream of the instruction ROM: it owns the PC register that addresses `InstROM` and takes the decoder's branch/halt controls back in. It also sequences program start, the halt/`done` handshake to the testbench, and a retired-instruction counter for benchmarking. One instruction per cycle, no pipelining.

## Interface
Parameters:
- `IW`, 16, PC width; the PC drives `InstAddress`.
- `START_ADDR`, 0, PC value loaded on reset and on every start.
- `CW`, 16, width of the retired-instruction counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  single-cycle request to begin or restart execution.
- `halt_i`  in  1  decoder halt control for the current instruction.
- `branch_i`  in  1  decoder branch control for the current instruction.
- `branch_type_i`  in  1  0 = relative, conditional on `zero_i`; 1 = absolute, unconditional.
- `zero_i`  in  1  ALU zero flag for the current instruction.
- `target_i`  in  8  branchLUT output: signed offset (relative) or unsigned address (absolute).
- `pc_o`  out  IW  current PC, combinationally feeds the instruction ROM.
- `run_o`  out  1  high while in RUN.
- `done`  out  1  high while in HALTED.
- `icount_o`  out  CW  instructions retired since the last start.

## Operation
- States: IDLE, RUN, HALTED, encoded in 2 bits. The fourth encoding recovers to IDLE on the next edge.
- Reset, from any state and mid-run included: state = IDLE, `pc_o` = START_ADDR, `icount_o` = 0, `run_o` = 0, `done` = 0.
- IDLE:
  - `start` = 1: go to RUN. PC stays START_ADDR, count is cleared.
  - Otherwise hold. `halt_i`, `branch_i` and the other inputs are ignored.
- RUN: each cycle the instruction at `pc_o` retires.
  - `icount_o` increments by 1, saturating at 2^CW−1 (no wrap).
  - Next-PC priority, highest first:
    1. `halt_i` = 1: PC holds, state goes to HALTED. The halt instruction is counted.
    2. `branch_i` = 1 and `branch_type_i` = 1: PC = zero-extend(`target_i`).
    3. `branch_i` = 1, `branch_type_i` = 0 and `zero_i` = 1: PC = PC + sign-extend(`target_i`), mod 2^IW.
    4. Otherwise (including a relative branch with `zero_i` = 0): PC = PC + 1, mod 2^IW.
  - `start` is ignored in RUN.
- HALTED:
  - PC and `icount_o` are frozen. `done` = 1, `run_o` = 0.
  - `start` = 1: PC = START_ADDR, `icount_o` = 0, state goes to RUN.
- `reset` and `start` in the same cycle: reset wins, state goes to IDLE.
- `halt_i` and `branch_i` in the same cycle: halt wins and the branch is discarded.
- Arithmetic:
  - Relative target is PC + {{(IW−8){target_i[7]}}, target_i}, truncated to IW bits.
  - Wrap is silent: 0xFFFF+1 → 0x0000; 0x0002 + (−4) → 0xFFFE.

## Timing
- All state changes happen on the rising edge of `clk`. `pc_o`, `run_o`, `done` and `icount_o` are registered outputs.
- Next-PC is computed combinationally from inputs that are valid in the same cycle as `pc_o`. This is a single-cycle datapath: ROM → decoder → ALU → back to this block within one clock.
- Latencies:
  - `start` sampled at edge N: `run_o` = 1 after edge N. First instruction (START_ADDR) retires at edge N+1.
  - Halt instruction retires at edge M: `done` = 1 and `run_o` = 0 after edge M. `done` stays asserted until reset or start.
- Branch taken at edge K: the target instruction is presented after edge K. There is no delay slot and no bubble.

## Test plan
- Reset then idle: assert `reset` 2 cycles, hold `start` = 0 for 10 cycles → `pc_o` = 0, `icount_o` = 0, `run_o` = 0, `done` = 0 throughout. `halt_i`/`branch_i` toggling has no effect.
- Sequential run and halt: pulse `start`, no branches for 5 cycles, then `halt_i` = 1 at PC = 5 → PC steps 0,1,2,3,4,5. After the halt edge: `done` = 1, `pc_o` = 5, `icount_o` = 6, all held for 10 further cycles.
- Branches:
  - At PC = 3, relative `target_i` = 0xFE, `zero_i` = 1 → next PC = 1.
  - Same branch with `zero_i` = 0 → next PC = 4.
  - At PC = 4, absolute `target_i` = 0x80 → next PC = 0x0080.
- Wrap and priority:
  - Absolute jump to 0xFF, then relative +0x7F → PC = 0x017E.
  - Force PC = 0xFFFF (START_ADDR = 0xFFFF build) → next sequential PC = 0x0000.
  - `halt_i` and `branch_i` together at PC = 7 → PC stays 7, `done` = 1.
- Restart and reset mid-run:
  - From HALTED with `icount_o` = 6, pulse `start` → PC = 0, `icount_o` = 0, `run_o` = 1 next cycle.
  - Assert `reset` together with `start` at PC = 9 → IDLE, PC = 0, `run_o` = 0.
- Counter saturation (CW = 4 build): run 20 cycles with no halt → `icount_o` sticks at 15.
